// File: rtl/game_pkg.sv
// Shared game constants for the shooter: screen geometry, the wave state
// encoding and the pixel-coordinate type.
// No ports.
package game_pkg;

    localparam int unsigned SCREEN_W   = 640;
    localparam int unsigned SCREEN_H   = 480;
    localparam int unsigned ENEMY_SIZE = 20;

    // Wave/level state encoding, visible on the wave_state debug output.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SPAWN = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;
    localparam logic [1:0] ST_INTER = 2'd3;

    typedef logic [9:0] coord_t;

    // Feedback tap mask for a maximal-length Fibonacci LFSR of the given width.
    // Bit k set means register bit k feeds the XOR.
    function automatic logic [31:0] lfsr_taps(input int unsigned width);
        case (width)
            4:       return 32'h0000_000C;  // x^4+x^3+1
            8:       return 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
            10:      return 32'h0000_0240;  // x^10+x^7+1
            12:      return 32'h0000_0829;  // x^12+x^6+x^4+x+1
            16:      return 32'h0000_B400;  // x^16+x^14+x^13+x^11+1
            default: return 32'h0000_0240;
        endcase
    endfunction

endpackage

// File: rtl/enemy_wave_spawner_if.sv
// Bundle between the enemy wave spawner and game_top.
// master : game_top side (drives enable and kill_req, reads enemy state)
// slave  : spawner side
//   enable        game running
//   kill_req      per-slot kill request, held until enemy_active falls
//   enemy_active  slot occupied
//   enemy_x/y     flattened positions, slot i at [10i+9:10i]
//   level         current level
//   wave_active   high while spawning or holding
//   escaped_cnt   enemies that timed out (saturating)
//   wave_state    FSM state for debug
interface enemy_wave_spawner_if
    import game_pkg::*;
#(
    parameter int unsigned MAX_ENEMIES = 10
);

    logic                                   enable;
    logic [MAX_ENEMIES-1:0]                 kill_req;
    logic [MAX_ENEMIES-1:0]                 enemy_active;
    logic [MAX_ENEMIES*$bits(coord_t)-1:0]  enemy_x;
    logic [MAX_ENEMIES*$bits(coord_t)-1:0]  enemy_y;
    logic [3:0]                             level;
    logic                                   wave_active;
    logic [7:0]                             escaped_cnt;
    logic [1:0]                             wave_state;

    modport master (
        output enable, kill_req,
        input  enemy_active, enemy_x, enemy_y, level, wave_active, escaped_cnt, wave_state
    );

    modport slave (
        input  enable, kill_req,
        output enemy_active, enemy_x, enemy_y, level, wave_active, escaped_cnt, wave_state
    );

endinterface

// File: rtl/lfsr_gen.sv
// Free-running Fibonacci LFSR; shifts on every clock edge.
// Ports:
//   clk    shift clock
//   rst    asynchronous active-high reset, loads SEED
//   value  current register contents
module lfsr_gen #(
    parameter int unsigned      WIDTH = 10,
    parameter logic [WIDTH-1:0] SEED  = '1,
    parameter logic [WIDTH-1:0] TAPS  = '1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) value <= SEED;
        else     value <= {value[WIDTH-2:0], ^(value & TAPS)};
    end

endmodule

// File: rtl/enemy_wave_spawner.sv
// Enemy population manager on the slow game tick: a pool of enemy slots,
// an LFSR for spawn positions and a wave/level state machine.
// Ports:
//   clk_1Hz  game tick clock
//   rst      asynchronous active-high reset
//   bus      enemy_wave_spawner_if.slave (enable, kill_req in; enemy state out)
// Build option: define ENEMY_DRIFT_EN to make enemies fall by DRIFT_STEP
// pixels per tick and escape when they would leave the bottom of the screen.
module enemy_wave_spawner
    import game_pkg::*;
#(
    parameter int unsigned       MAX_ENEMIES  = 10,
    parameter int unsigned       LFSR_W       = 10,
    parameter logic [LFSR_W-1:0] LFSR_SEED    = 10'h280,
    parameter int unsigned       SCREEN_W     = game_pkg::SCREEN_W,
    parameter int unsigned       SCREEN_H     = game_pkg::SCREEN_H,
    parameter int unsigned       ENEMY_SIZE   = game_pkg::ENEMY_SIZE,
    parameter int unsigned       LIFETIME     = 15,
    parameter int unsigned       WAVE_BASE    = 3,
    parameter int unsigned       MAX_LEVEL    = 7,
    parameter int unsigned       INTERMISSION = 3,
    parameter int unsigned       DRIFT_STEP   = 8
) (
    input  logic                 clk_1Hz,
    input  logic                 rst,
    enemy_wave_spawner_if.slave  bus
);

    localparam int unsigned X_RANGE = SCREEN_W - ENEMY_SIZE;
    localparam int unsigned Y_RANGE = SCREEN_H - ENEMY_SIZE;

`ifdef ENEMY_DRIFT_EN
    localparam bit DRIFT_ON = 1'b1;
`else
    localparam bit DRIFT_ON = 1'b0;
`endif

    // ---------------- spawn position source ----------------
    logic [LFSR_W-1:0] lfsr;
    logic [LFSR_W-1:0] lfsr_rot;
    coord_t            spawn_x;
    coord_t            spawn_y;

    lfsr_gen #(
        .WIDTH (LFSR_W),
        .SEED  (LFSR_SEED),
        .TAPS  (LFSR_W'(lfsr_taps(LFSR_W)))
    ) u_lfsr (
        .clk   (clk_1Hz),
        .rst   (rst),
        .value (lfsr)
    );

    // The pre-shift LFSR value feeds this tick's spawn.
    assign lfsr_rot = (lfsr << (LFSR_W / 2)) | (lfsr >> (LFSR_W - LFSR_W / 2));
    assign spawn_x  = coord_t'(32'(lfsr) % X_RANGE);
    assign spawn_y  = coord_t'(32'(lfsr_rot) % Y_RANGE);

    // ---------------- wave state ----------------
    logic [1:0] state, state_next;
    logic [7:0] spawned, spawned_next;
    logic [7:0] inter_cnt, inter_next;
    logic [3:0] level_r, level_next;
    logic [7:0] esc_cnt, esc_next;
    logic       wave_active_r;
    logic [7:0] quota;

    logic [MAX_ENEMIES-1:0] active;
    logic [MAX_ENEMIES-1:0] free;
    logic [MAX_ENEMIES-1:0] spawn_sel;
    logic [MAX_ENEMIES-1:0] escape;
    logic                   spawn_go;

    assign quota = 8'(WAVE_BASE) + 8'(level_r);
    assign free  = ~active;

    // Slots freed this tick are still marked active here, so they only
    // become spawnable on the following tick.
    assign spawn_go  = bus.enable && (state == ST_SPAWN) && (spawned < quota) && (|free);
    assign spawn_sel = spawn_go ? (free & (~free + MAX_ENEMIES'(1))) : '0;

    // ---------------- enemy slots ----------------
    for (genvar i = 0; i < MAX_ENEMIES; i++) begin : g_slot
        logic       act;
        logic [7:0] age;
        coord_t     x;
        coord_t     y;
        logic       live;
        logic       expire;
        logic       bottom;

        // Kill overrides every other event on the slot.
        assign live   = bus.enable && act && !bus.kill_req[i];
        assign bottom = DRIFT_ON && live && ((32'(y) + DRIFT_STEP) > Y_RANGE);
        assign expire = live && !bottom && (age == 8'(LIFETIME - 1));
        assign escape[i] = bottom | expire;

        always_ff @(posedge clk_1Hz or posedge rst) begin
            if (rst) begin
                act <= 1'b0;
                age <= '0;
                x   <= '0;
                y   <= '0;
            end else if (act) begin
                if (bus.kill_req[i] || escape[i]) begin
                    act <= 1'b0;
                end else if (bus.enable) begin
                    age <= age + 8'd1;
                    if (DRIFT_ON) y <= y + coord_t'(DRIFT_STEP);
                end
            end else if (spawn_sel[i]) begin
                act <= 1'b1;
                age <= '0;
                x   <= spawn_x;
                y   <= spawn_y;
            end
        end

        assign active[i] = act;
        assign bus.enemy_x[$bits(coord_t)*i +: $bits(coord_t)] = x;
        assign bus.enemy_y[$bits(coord_t)*i +: $bits(coord_t)] = y;
    end

    // ---------------- escape counter ----------------
    always_comb begin
        logic [4:0] pop;
        logic [8:0] sum;
        pop = '0;
        for (int unsigned i = 0; i < MAX_ENEMIES; i++) pop = pop + 5'(escape[i]);
        sum      = 9'(esc_cnt) + 9'(pop);
        esc_next = sum[8] ? 8'hFF : sum[7:0];
    end

    // ---------------- FSM ----------------
    always_comb begin
        state_next   = state;
        spawned_next = spawned;
        inter_next   = inter_cnt;
        level_next   = level_r;
        if (bus.enable) begin
            case (state)
                ST_IDLE: begin
                    state_next   = ST_SPAWN;
                    spawned_next = '0;
                end
                ST_SPAWN: begin
                    if (spawned >= quota)  state_next   = ST_HOLD;
                    else if (spawn_go)     spawned_next = spawned + 8'd1;
                end
                ST_HOLD: begin
                    if (active == '0) begin
                        state_next = ST_INTER;
                        inter_next = 8'(INTERMISSION);
                        level_next = (level_r >= 4'(MAX_LEVEL)) ? 4'(MAX_LEVEL) : level_r + 4'd1;
                    end
                end
                default: begin
                    // Counter reaches zero on the tick that leaves INTER, so a
                    // load of N gives exactly N idle ticks.
                    if (inter_cnt <= 8'd1) begin
                        state_next   = ST_SPAWN;
                        spawned_next = '0;
                        inter_next   = '0;
                    end else begin
                        inter_next = inter_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_1Hz or posedge rst) begin
        if (rst) begin
            state         <= ST_INTER;
            spawned       <= '0;
            inter_cnt     <= 8'(INTERMISSION);
            level_r       <= '0;
            esc_cnt       <= '0;
            wave_active_r <= 1'b0;
        end else begin
            state         <= state_next;
            spawned       <= spawned_next;
            inter_cnt     <= inter_next;
            level_r       <= level_next;
            esc_cnt       <= esc_next;
            wave_active_r <= (state_next == ST_SPAWN) || (state_next == ST_HOLD);
        end
    end

    assign bus.enemy_active = active;
    assign bus.level        = level_r;
    assign bus.wave_active  = wave_active_r;
    assign bus.escaped_cnt  = esc_cnt;
    assign bus.wave_state   = state;

endmodule

// File: tb/tb_enemy_wave_spawner.sv
// Self-checking bench for enemy_wave_spawner with a 4-slot pool so that the
// larger waves exercise deferred spawns.
module tb_enemy_wave_spawner;

    localparam int N     = 4;
    localparam int LIFE  = 15;
    localparam int BASE  = 3;
    localparam int MAXL  = 7;
    localparam int INTER = 3;
    localparam int SEED  = 10'h280;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    enemy_wave_spawner_if #(.MAX_ENEMIES(N)) bus ();

    enemy_wave_spawner #(
        .MAX_ENEMIES  (N),
        .LFSR_W       (10),
        .LFSR_SEED    (10'h280),
        .LIFETIME     (LIFE),
        .WAVE_BASE    (BASE),
        .MAX_LEVEL    (MAXL),
        .INTERMISSION (INTER)
    ) dut (
        .clk_1Hz (clk),
        .rst     (rst),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    // drive copies of the inputs, used by the model at each edge
    bit           en_drv;
    logic [N-1:0] kill_drv;

    // reference model: phase uses the numbering 0 idle, 1 spawn, 2 hold, 3 intermission
    int m_act[N], m_age[N], m_x[N], m_y[N];
    int m_lfsr, m_phase, m_level, m_esc, m_spawned, m_wait;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_act[i] = 0; m_age[i] = 0; m_x[i] = 0; m_y[i] = 0;
        end
        m_lfsr = SEED; m_phase = 3; m_level = 0; m_esc = 0; m_spawned = 0; m_wait = INTER;
    endtask

    task automatic model_step(input bit en, input logic [N-1:0] kill);
        int px, py, rot, first_free, any_active, expired;
        px  = m_lfsr % 620;
        rot = ((m_lfsr << 5) | (m_lfsr >> 5)) & 1023;
        py  = rot % 460;
        first_free = -1;
        any_active = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_act[i] == 0) first_free = i;
            else any_active = 1;
        end
        expired = 0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] != 0) begin
                if (kill[i]) m_act[i] = 0;
                else if (en) begin
                    if (m_age[i] == LIFE - 1) begin m_act[i] = 0; expired++; end
                    else m_age[i]++;
                end
            end
        end
        m_esc = (m_esc + expired > 255) ? 255 : m_esc + expired;
        if (en) begin
            case (m_phase)
                0: begin m_phase = 1; m_spawned = 0; end
                1: begin
                    if (m_spawned >= BASE + m_level) m_phase = 2;
                    else if (first_free >= 0) begin
                        m_act[first_free] = 1; m_age[first_free] = 0;
                        m_x[first_free] = px;  m_y[first_free] = py;
                        m_spawned++;
                    end
                end
                2: if (!any_active) begin
                    m_phase = 3; m_wait = INTER;
                    m_level = (m_level >= MAXL) ? MAXL : m_level + 1;
                end
                default: begin
                    if (m_wait <= 1) begin m_phase = 1; m_spawned = 0; m_wait = 0; end
                    else m_wait--;
                end
            endcase
        end
        m_lfsr = ((m_lfsr << 1) & 1023) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
    endtask

    task automatic compare_all(input string tag);
        logic [N-1:0]    e_act;
        logic [N*10-1:0] e_x, e_y;
        logic            in_bounds;
        in_bounds = 1'b1;
        for (int i = 0; i < N; i++) begin
            e_act[i]          = (m_act[i] != 0);
            e_x[10*i +: 10]   = 10'(m_x[i]);
            e_y[10*i +: 10]   = 10'(m_y[i]);
            if (bus.enemy_active[i] &&
                (bus.enemy_x[10*i +: 10] >= 10'd620 || bus.enemy_y[10*i +: 10] >= 10'd460))
                in_bounds = 1'b0;
        end
        chk({tag, ".active"},   128'(bus.enemy_active), 128'(e_act));
        chk({tag, ".x"},        128'(bus.enemy_x),      128'(e_x));
        chk({tag, ".y"},        128'(bus.enemy_y),      128'(e_y));
        chk({tag, ".level"},    128'(bus.level),        128'(m_level));
        chk({tag, ".escaped"},  128'(bus.escaped_cnt),  128'(m_esc));
        chk({tag, ".state"},    128'(bus.wave_state),   128'(m_phase));
        chk({tag, ".wave_act"}, 128'(bus.wave_active),  128'((m_phase == 1) || (m_phase == 2)));
        chk({tag, ".bounds"},   128'(in_bounds),        128'(1));
    endtask

    task automatic reset_values(input string tag);
        chk({tag, ".active"},   128'(bus.enemy_active), 128'(0));
        chk({tag, ".x"},        128'(bus.enemy_x),      128'(0));
        chk({tag, ".y"},        128'(bus.enemy_y),      128'(0));
        chk({tag, ".level"},    128'(bus.level),        128'(0));
        chk({tag, ".escaped"},  128'(bus.escaped_cnt),  128'(0));
        chk({tag, ".wave_act"}, 128'(bus.wave_active),  128'(0));
        chk({tag, ".state"},    128'(bus.wave_state),   128'(3));
    endtask

    task automatic drive(input bit en, input logic [N-1:0] kill);
        en_drv = en; kill_drv = kill;
        bus.enable = en; bus.kill_req = kill;
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step(en_drv, kill_drv);
        #1;
        compare_all(tag);
    endtask

    function automatic logic [N-1:0] random_kills();
        logic [N-1:0] k;
        k = '0;
        for (int i = 0; i < N; i++) begin
            if (m_act[i] != 0) begin
                if (m_age[i] == LIFE - 1 && $urandom_range(0, 2) == 0) k[i] = 1'b1;
                else if ($urandom_range(0, 11) == 0) k[i] = 1'b1;
            end
        end
        if ($urandom_range(0, 19) == 0) k[$urandom_range(0, N - 1)] = 1'b1;
        return k;
    endfunction

    initial begin
        drive(1'b0, '0);
        #1 rst = 1'b1;
        #2;
        model_reset();
        reset_values("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // full waves without kills: lifetime expiry and level progression
        drive(1'b1, '0);
        for (int t = 0; t < 45; t++) tick("plain");

        // frozen game: only the LFSR moves
        drive(1'b0, '0);
        for (int t = 0; t < 5; t++) tick("frozen");

        // randomized play
        for (int t = 0; t < 450; t++) begin
            drive($urandom_range(0, 9) != 0, random_kills());
            tick("random");
        end

        // asynchronous reset between edges
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        reset_values("async_rst");
        drive(1'b1, '0);
        @(posedge clk);
        #1 rst = 1'b0;

        for (int t = 0; t < 120; t++) begin
            drive($urandom_range(0, 7) != 0, random_kills());
            tick("after_rst");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
